// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encodings, digit width, wrap defaults and BCD helper
package stopwatch_pkg;
  localparam int DIGIT_W = 4;
  localparam int SEC_MAX_DEF = 59;
  localparam int MIN_MAX_DEF = 59;
  typedef enum logic [1:0] {COUNT = 2'd0, PAUSED = 2'd1, ADJUST = 2'd2} state_t;
  function automatic logic [2*DIGIT_W-1:0] to_bcd(input int v);
    return {DIGIT_W'(v / 10), DIGIT_W'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_mod60.sv
// bcd_mod60: two-digit BCD counter wrapping at a BCD max value, carry out on wrap
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic [2*DIGIT_W-1:0]   max,
  output logic [DIGIT_W-1:0]     tens,
  output logic [DIGIT_W-1:0]     ones,
  output logic                   carry
);
  logic at_max;
  assign at_max = {tens, ones} == max;
  assign carry = inc & at_max;
  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      tens <= at_max ? '0 : (ones == DIGIT_W'(9) ? tens + 1'b1 : tens);
      ones <= (at_max || ones == DIGIT_W'(9)) ? '0 : ones + 1'b1;
    end
  end
endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD stopwatch with pause and adjust; STOPWATCH_BLINK_EN adds field blink
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               tick_2hz,
  input  logic               tick_blink,
  input  logic               pause_pulse,
  input  logic               adj,
  input  logic               sel,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [1:0]         mode,
  output logic               blank_min,
  output logic               blank_sec
);
  state_t state, state_n;
  logic paused, paused_n;
  logic count_tick, adj_tick, sec_inc, min_inc, sec_carry, unused_min_carry;
  assign paused_n = paused ^ pause_pulse;
  // Leaving ADJUST and pausing outside it resolve identically through the updated flag
  always_comb state_n = (state == state_t'(2'd3)) ? COUNT : adj ? ADJUST : paused_n ? PAUSED : COUNT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= COUNT;
      paused <= 1'b0;
    end else begin
      state  <= state_n;
      paused <= paused_n;
    end
  end
  assign mode = state;
  assign count_tick = (state == COUNT) & tick_1hz & ~pause_pulse;
  assign adj_tick = (state == ADJUST) & tick_2hz;
  assign sec_inc = count_tick | (adj_tick & sel);
  assign min_inc = (count_tick & sec_carry) | (adj_tick & ~sel);
  bcd_mod60 u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc), .max(to_bcd(SEC_MAX)),
    .tens(sec_tens), .ones(sec_ones), .carry(sec_carry)
  );
  bcd_mod60 u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .max(to_bcd(MIN_MAX)),
    .tens(min_tens), .ones(min_ones), .carry(unused_min_carry)
  );
`ifdef STOPWATCH_BLINK_EN
  logic phase;
  always_ff @(posedge clk) begin
    if (rst || state != ADJUST) phase <= 1'b0;
    else if (tick_blink) phase <= ~phase;
  end
  assign blank_min = (state == ADJUST) & ~sel & phase;
  assign blank_sec = (state == ADJUST) & sel & phase;
`else
  logic unused_blink;
  assign unused_blink = tick_blink;
  assign blank_min = 1'b0;
  assign blank_sec = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed self-checking bench for stopwatch_counter
module tb_stopwatch_counter;
  logic clk = 0, rst = 0, tick_1hz = 0, tick_2hz = 0, tick_blink = 0, pause_pulse = 0, adj = 0, sel = 0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] mode;
  logic blank_min, blank_sec;
  int checks = 0, errors = 0;
  stopwatch_counter dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_blink(tick_blink),
    .pause_pulse(pause_pulse), .adj(adj), .sel(sel), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .mode(mode), .blank_min(blank_min), .blank_sec(blank_sec)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic tick1(input int n);
    repeat (n) begin tick_1hz = 1; cyc(1); tick_1hz = 0; cyc(1); end
  endtask
  task automatic tick2(input int n);
    repeat (n) begin tick_2hz = 1; cyc(1); tick_2hz = 0; cyc(1); end
  endtask
  task automatic blink1();
    tick_blink = 1; cyc(1); tick_blink = 0; cyc(1);
  endtask
  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction
  logic exp_blink;
  initial begin
    rst = 1; cyc(2); rst = 0;
    check("reset_digits", digits(), 16'h0000);
    check("reset_mode", mode, 0);
    check("reset_blanks", {blank_min, blank_sec}, 0);
    tick1(75);
    check("count75_digits", digits(), 16'h0115);
    check("count75_mode", mode, 0);
    adj = 1; sel = 0; cyc(1);
    check("adjust_mode", mode, 2);
    tick2(58); sel = 1; tick2(43);
    adj = 0; cyc(1);
    check("preload_digits", digits(), 16'h5958);
    check("preload_mode", mode, 0);
    tick1(1);
    check("wrap_pre", digits(), 16'h5959);
    tick_1hz = 1; cyc(1); tick_1hz = 0;
    check("wrap_full", digits(), 16'h0000);
    cyc(1);
    tick1(10);
    check("at_0010", digits(), 16'h0010);
    pause_pulse = 1; tick_1hz = 1; cyc(1); pause_pulse = 0; tick_1hz = 0;
    check("pause_tick_digits", digits(), 16'h0010);
    check("pause_tick_mode", mode, 1);
    tick1(5);
    check("paused_hold", digits(), 16'h0010);
    adj = 1; sel = 1; cyc(1);
    tick2(48);
    check("adj_to_0058", digits(), 16'h0058);
    tick2(3);
    check("adj_sec_wrap", digits(), 16'h0001);
    tick1(1);
    check("adj_ignore_1hz", digits(), 16'h0001);
    adj = 0; cyc(1);
    check("leave_adj_paused", mode, 1);
    pause_pulse = 1; cyc(1); pause_pulse = 0;
    check("resume_mode", mode, 0);
    tick1(1);
    check("resume_count", digits(), 16'h0002);
    adj = 1; sel = 0; cyc(1);
    tick2(12); sel = 1; tick2(32);
    check("adj_1234", digits(), 16'h1234);
    check("adj_1234_mode", mode, 2);
    rst = 1; tick_1hz = 1; tick_2hz = 1; pause_pulse = 1; tick_blink = 1; cyc(1);
    rst = 0; tick_1hz = 0; tick_2hz = 0; pause_pulse = 0; tick_blink = 0; adj = 0;
    check("rst_adj_digits", digits(), 16'h0000);
    check("rst_adj_mode", mode, 0);
    check("rst_adj_blanks", {blank_min, blank_sec}, 0);
    tick1(1);
    check("post_rst_count", digits(), 16'h0001);
    check("post_rst_mode", mode, 0);
    adj = 1; sel = 0; cyc(1);
    for (int i = 0; i < 4; i++) begin
      blink1();
`ifdef STOPWATCH_BLINK_EN
      exp_blink = (i % 2) == 0;
`else
      exp_blink = 0;
`endif
      check($sformatf("blank_min_%0d", i), blank_min, exp_blink);
      check($sformatf("blank_sec_%0d", i), blank_sec, 0);
    end
    sel = 1; blink1();
`ifdef STOPWATCH_BLINK_EN
    exp_blink = 1;
`else
    exp_blink = 0;
`endif
    check("blank_sec_sel", blank_sec, exp_blink);
    check("blank_min_sel", blank_min, 0);
    adj = 0; cyc(1);
    check("leave_blank", {blank_min, blank_sec}, 0);
    adj = 1; cyc(1);
    check("reenter_phase_clear", {blank_min, blank_sec}, 0);
    check("blink_digits_held", digits(), 16'h0001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
